// File: rtl/dfi_lp_handshake_checker.sv
// dfi_lp_handshake_checker
// Passive monitor for the DFI low-power handshake (lp_req / lp_ack) on
// NUM_CH independent channels. Each channel tracks the handshake phase
// (IDLE, REQ, LP, EXIT) with a saturating cycle timer. It flags:
//   - protocol violations (err_proto)
//   - response / exit timeouts (err_timeout)
//   - command traffic while a low-power request is pending or granted (err_cmd)
//   - optional wakeup-code changes during REQ/LP (err_wakeup)
// Flags are sticky and set one edge after the offending cycle. err_count
// accumulates every event across all channels and types, and saturates.
// err_clr clears the flags and the count but leaves the channel FSMs alone.
//
// Build option: define DFI_LP_WAKEUP_CHK_EN to enable the wakeup-code
// stability check. Without it, err_wakeup is tied to 0 and lp_wakeup is
// ignored.
module dfi_lp_handshake_checker #(
    parameter int NUM_CH   = 2,
    parameter int TLP_RESP = 8,
    parameter int TLP_EXIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_CH-1:0]     lp_req,
    input  logic [NUM_CH-1:0]     lp_ack,
    input  logic [6*NUM_CH-1:0]   lp_wakeup,
    input  logic [NUM_CH-1:0]     cmd_active,
    input  logic                  err_clr,
    output logic [2*NUM_CH-1:0]   lp_state,
    output logic [NUM_CH-1:0]     err_proto,
    output logic [NUM_CH-1:0]     err_timeout,
    output logic [NUM_CH-1:0]     err_cmd,
    output logic [NUM_CH-1:0]     err_wakeup,
    output logic [CNT_W-1:0]      err_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_LP   = 2'd2,
        ST_EXIT = 2'd3
    } lp_state_t;

    // The timer must be able to exceed the larger limit. Once it saturates,
    // the "equals limit" compare cannot fire again.
    localparam int TMAX = (TLP_RESP > TLP_EXIT) ? TLP_RESP : TLP_EXIT;
    localparam int TW   = $clog2(TMAX + 2);
    localparam logic [TW-1:0] TIMER_MAX = {TW{1'b1}};
    localparam logic [TW-1:0] RESP_LIM  = TW'(TLP_RESP);
    localparam logic [TW-1:0] EXIT_LIM  = TW'(TLP_EXIT);

    // Up to four event types per channel can fire in one cycle.
    localparam int EW = $clog2(4 * NUM_CH + 1);
    // Sum width covers both operands plus a carry, so saturation detection
    // works even when CNT_W is narrower than the per-cycle event total.
    localparam int SW = ((CNT_W > EW) ? CNT_W : EW) + 1;
    localparam logic [SW-1:0] CNT_MAX = (SW'(1) << CNT_W) - SW'(1);

    logic [NUM_CH-1:0] w_ev_proto;
    logic [NUM_CH-1:0] w_ev_timeout;
    logic [NUM_CH-1:0] w_ev_cmd;
    logic [NUM_CH-1:0] w_ev_wakeup;

    logic [NUM_CH-1:0] r_err_proto;
    logic [NUM_CH-1:0] r_err_timeout;
    logic [NUM_CH-1:0] r_err_cmd;
    logic [CNT_W-1:0]  r_err_count;

    logic [EW-1:0]     w_ev_total;
    logic [SW-1:0]     w_count_sum;
    logic [CNT_W-1:0]  w_count_next;

    // ------------------------------------------------------------------
    // Per-channel handshake tracker
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        lp_state_t     r_state;
        lp_state_t     w_state_next;
        logic [TW-1:0] r_timer;
        logic [TW-1:0] w_timer_next;
        logic          w_req;
        logic          w_ack;
        logic          w_proto;
        logic          w_tmo;

        assign w_req = lp_req[gi];
        assign w_ack = lp_ack[gi];

        // Phase register and time-in-phase counter
        always_ff @(posedge clock) begin
            if (!reset) begin
                r_state <= ST_IDLE;
                r_timer <= '0;
            end else begin
                r_state <= w_state_next;
                r_timer <= w_timer_next;
            end
        end

        // Handshake transitions plus protocol and timeout event decode
        always_comb begin
            w_state_next = r_state;
            w_proto      = 1'b0;
            w_tmo        = 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req && w_ack) begin
                        // ack arrived together with req: accept but flag it
                        w_state_next = ST_LP;
                        w_proto      = 1'b1;
                    end else if (w_req) begin
                        w_state_next = ST_REQ;
                    end else if (w_ack) begin
                        // ack with no request at all
                        w_proto = 1'b1;
                    end
                end
                ST_REQ: begin
                    if (w_ack) begin
                        w_state_next = ST_LP;
                    end else if (!w_req) begin
                        // Withdrawing req is only legal after the response window
                        w_state_next = ST_IDLE;
                        w_proto      = (r_timer < RESP_LIM);
                    end else begin
                        w_tmo = (r_timer == RESP_LIM);
                    end
                end
                ST_LP: begin
                    if (!w_req) begin
                        w_state_next = ST_EXIT;
                    end else if (!w_ack) begin
                        // ack dropped while still requested
                        w_state_next = ST_IDLE;
                        w_proto      = 1'b1;
                    end
                end
                ST_EXIT: begin
                    if (!w_ack) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_tmo   = (r_timer == EXIT_LIM);
                        w_proto = w_req;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end

        // Timer restarts on every phase change and otherwise saturates
        assign w_timer_next = (w_state_next != r_state) ? '0 :
                              (r_timer == TIMER_MAX)    ? r_timer :
                                                          r_timer + TW'(1);

        assign w_ev_proto[gi]   = w_proto;
        assign w_ev_timeout[gi] = w_tmo;
        assign w_ev_cmd[gi]     = ((r_state == ST_REQ) || (r_state == ST_LP)) && cmd_active[gi];
        assign lp_state[2*gi +: 2] = r_state;

`ifdef DFI_LP_WAKEUP_CHK_EN
        logic [5:0] r_wakeup_prev;
        logic [5:0] w_wakeup_cur;

        assign w_wakeup_cur = lp_wakeup[6*gi +: 6];

        // Previous-cycle wakeup code, used to detect changes
        always_ff @(posedge clock) begin
            if (!reset) begin
                r_wakeup_prev <= '0;
            end else begin
                r_wakeup_prev <= w_wakeup_cur;
            end
        end

        assign w_ev_wakeup[gi] = ((r_state == ST_REQ) || (r_state == ST_LP)) &&
                                 (w_wakeup_cur != r_wakeup_prev);
`else
        assign w_ev_wakeup[gi] = 1'b0;
`endif
    end : g_ch

`ifndef DFI_LP_WAKEUP_CHK_EN
    // The wakeup code is not examined in this build
    logic w_unused_wakeup;
    assign w_unused_wakeup = ^lp_wakeup;
`endif

    // ------------------------------------------------------------------
    // Event accounting
    // ------------------------------------------------------------------

    // Number of events raised this cycle across all channels and types
    always_comb begin
        w_ev_total = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_ev_total = w_ev_total + EW'(w_ev_proto[i]) + EW'(w_ev_timeout[i])
                                    + EW'(w_ev_cmd[i])   + EW'(w_ev_wakeup[i]);
        end
    end

    assign w_count_sum  = SW'(r_err_count) + SW'(w_ev_total);
    assign w_count_next = (w_count_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0]
                                                  : w_count_sum[CNT_W-1:0];

    // Sticky flags and saturating total. A clear wins over same-cycle events.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_err_proto   <= '0;
            r_err_timeout <= '0;
            r_err_cmd     <= '0;
            r_err_count   <= '0;
        end else if (err_clr) begin
            r_err_proto   <= '0;
            r_err_timeout <= '0;
            r_err_cmd     <= '0;
            r_err_count   <= '0;
        end else begin
            r_err_proto   <= r_err_proto   | w_ev_proto;
            r_err_timeout <= r_err_timeout | w_ev_timeout;
            r_err_cmd     <= r_err_cmd     | w_ev_cmd;
            r_err_count   <= w_count_next;
        end
    end

`ifdef DFI_LP_WAKEUP_CHK_EN
    logic [NUM_CH-1:0] r_err_wakeup;

    // Sticky wakeup-change flags, cleared alongside the others
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_err_wakeup <= '0;
        end else if (err_clr) begin
            r_err_wakeup <= '0;
        end else begin
            r_err_wakeup <= r_err_wakeup | w_ev_wakeup;
        end
    end

    assign err_wakeup = r_err_wakeup;
`else
    assign err_wakeup = '0;
`endif

    assign err_proto   = r_err_proto;
    assign err_timeout = r_err_timeout;
    assign err_cmd     = r_err_cmd;
    assign err_count   = r_err_count;

endmodule

// File: tb/tb_dfi_lp_handshake_checker.sv
// Testbench for dfi_lp_handshake_checker. A behavioural reference model
// derives the expected outputs from the handshake rules. A compare process
// checks both DUT instances against the model every cycle. Directed
// scenarios also add hand-computed literal checks.
module tb_dfi_lp_handshake_checker;

    localparam int NUM_CH   = 2;
    localparam int TLP_RESP = 8;
    localparam int TLP_EXIT = 16;

    logic                 clock;
    logic                 reset;
    logic [NUM_CH-1:0]    lp_req;
    logic [NUM_CH-1:0]    lp_ack;
    logic [6*NUM_CH-1:0]  lp_wakeup;
    logic [NUM_CH-1:0]    cmd_active;
    logic                 err_clr;

    logic [2*NUM_CH-1:0]  lp_state;
    logic [NUM_CH-1:0]    err_proto, err_timeout, err_cmd, err_wakeup;
    logic [15:0]          err_count;

    logic [2*NUM_CH-1:0]  b_unused_state;
    logic [NUM_CH-1:0]    b_unused_proto, b_unused_tmo, b_unused_cmd, b_unused_wk;
    logic [1:0]           err_count_b;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 0;

    dfi_lp_handshake_checker #(
        .NUM_CH(NUM_CH), .TLP_RESP(TLP_RESP), .TLP_EXIT(TLP_EXIT), .CNT_W(16)
    ) dut (
        .clock(clock), .reset(reset), .lp_req(lp_req), .lp_ack(lp_ack),
        .lp_wakeup(lp_wakeup), .cmd_active(cmd_active), .err_clr(err_clr),
        .lp_state(lp_state), .err_proto(err_proto), .err_timeout(err_timeout),
        .err_cmd(err_cmd), .err_wakeup(err_wakeup), .err_count(err_count)
    );

    // Narrow-counter instance used to observe saturation
    dfi_lp_handshake_checker #(
        .NUM_CH(NUM_CH), .TLP_RESP(TLP_RESP), .TLP_EXIT(TLP_EXIT), .CNT_W(2)
    ) dut_b (
        .clock(clock), .reset(reset), .lp_req(lp_req), .lp_ack(lp_ack),
        .lp_wakeup(lp_wakeup), .cmd_active(cmd_active), .err_clr(err_clr),
        .lp_state(b_unused_state), .err_proto(b_unused_proto), .err_timeout(b_unused_tmo),
        .err_cmd(b_unused_cmd), .err_wakeup(b_unused_wk), .err_count(err_count_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: phase per channel (0 idle, 1 requested, 2 low power,
    // 3 exiting), unbounded age in phase, plain integer event tally.
    // ------------------------------------------------------------------
    int                m_phase [NUM_CH];
    int                m_age   [NUM_CH];
    logic [5:0]        m_wk    [NUM_CH];
    logic [NUM_CH-1:0] m_proto, m_tmo, m_cmd, m_wkf;
    int                m_raw;

    function automatic int sat(input int raw, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (raw > mx) ? mx : raw;
    endfunction

    always @(posedge clock) begin : model
        int nxt, evs;
        bit rq, ak, p, t, cm, w;
        if (!reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_phase[c] = 0;
                m_age[c]   = 0;
                m_wk[c]    = '0;
            end
            m_proto = '0; m_tmo = '0; m_cmd = '0; m_wkf = '0;
            m_raw   = 0;
        end else begin
            evs = 0;
            for (int c = 0; c < NUM_CH; c++) begin
                rq = lp_req[c];
                ak = lp_ack[c];
                nxt = m_phase[c];
                p = 0; t = 0; w = 0;
                if (m_phase[c] == 0) begin
                    p = ak;                         // any ack while idle is illegal
                    if (rq) nxt = ak ? 2 : 1;
                end else if (m_phase[c] == 1) begin
                    if (ak) nxt = 2;
                    else if (!rq) begin nxt = 0; p = (m_age[c] < TLP_RESP); end
                    else t = (m_age[c] == TLP_RESP);
                end else if (m_phase[c] == 2) begin
                    if (!rq) nxt = 3;
                    else if (!ak) begin nxt = 0; p = 1; end
                end else begin
                    if (!ak) nxt = 0;
                    else begin t = (m_age[c] == TLP_EXIT); p = rq; end
                end
                cm = (m_phase[c] == 1 || m_phase[c] == 2) && cmd_active[c];
`ifdef DFI_LP_WAKEUP_CHK_EN
                w = (m_phase[c] == 1 || m_phase[c] == 2) && (lp_wakeup[6*c +: 6] != m_wk[c]);
`endif
                m_wk[c]  = lp_wakeup[6*c +: 6];
                m_age[c] = (nxt != m_phase[c]) ? 0 : m_age[c] + 1;
                m_phase[c] = nxt;
                evs = evs + int'(p) + int'(t) + int'(cm) + int'(w);
                m_proto[c] = m_proto[c] | p;
                m_tmo[c]   = m_tmo[c]   | t;
                m_cmd[c]   = m_cmd[c]   | cm;
                m_wkf[c]   = m_wkf[c]   | w;
            end
            if (err_clr) begin
                m_proto = '0; m_tmo = '0; m_cmd = '0; m_wkf = '0;
                m_raw   = 0;
            end else begin
                m_raw = m_raw + evs;
            end
        end
    end

    // Every-cycle comparison of both DUTs against the model
    always @(negedge clock) begin : compare
        logic [2*NUM_CH-1:0] es;
        if (chk_en) begin
            for (int c = 0; c < NUM_CH; c++) es[2*c +: 2] = 2'(m_phase[c]);
            chk("cyc_lp_state",    32'(lp_state),    32'(es));
            chk("cyc_err_proto",   32'(err_proto),   32'(m_proto));
            chk("cyc_err_timeout", 32'(err_timeout), 32'(m_tmo));
            chk("cyc_err_cmd",     32'(err_cmd),     32'(m_cmd));
            chk("cyc_err_wakeup",  32'(err_wakeup),  32'(m_wkf));
            chk("cyc_err_count",   32'(err_count),   32'(sat(m_raw, 16)));
            chk("cyc_err_count_b", 32'(err_count_b), 32'(sat(m_raw, 2)));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        cycles(1);
        err_clr = 1'b0;
    endtask

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus with literal expectations
    initial begin
        reset = 1'b0; lp_req = '0; lp_ack = '0; lp_wakeup = '0;
        cmd_active = '0; err_clr = 1'b0;
        cycles(2);
        chk_en = 1'b1;
        chk("rst_lp_state",  32'(lp_state),  32'h0);
        chk("rst_err_count", 32'(err_count), 32'h0);
        chk("rst_err_proto", 32'(err_proto), 32'h0);
        reset = 1'b1;
        cycles(1);

        // Clean handshake on channel 0
        lp_req[0] = 1'b1;            cycles(1);
        chk("ok_state_req",  32'(lp_state[1:0]), 32'd1);
        cycles(2);
        lp_ack[0] = 1'b1;            cycles(1);
        chk("ok_state_lp",   32'(lp_state[1:0]), 32'd2);
        cycles(6);
        lp_req[0] = 1'b0;            cycles(1);
        chk("ok_state_exit", 32'(lp_state[1:0]), 32'd3);
        cycles(1);
        lp_ack[0] = 1'b0;            cycles(1);
        chk("ok_state_idle", 32'(lp_state[1:0]), 32'd0);
        chk("ok_flags", 32'({err_proto, err_timeout, err_cmd, err_wakeup}), 32'h0);
        chk("ok_count", 32'(err_count), 32'd0);

        // Response timeout on channel 1
        lp_req[1] = 1'b1;            cycles(9);
        chk("resp_tmo_early", 32'(err_timeout), 32'b00);
        cycles(1);
        chk("resp_tmo_set",   32'(err_timeout), 32'b10);
        chk("resp_tmo_count", 32'(err_count),   32'd1);
        cycles(1);
        chk("resp_tmo_norepeat", 32'(err_count), 32'd1);
        lp_req[1] = 1'b0;            cycles(1);
        chk("resp_late_drop_state", 32'(lp_state[3:2]), 32'd0);
        chk("resp_late_drop_proto", 32'(err_proto),     32'b00);
        clear_errors();
        chk("clr_count", 32'(err_count), 32'd0);

        // Both channels ack without a request
        lp_ack = 2'b11;              cycles(1);
        lp_ack = 2'b00;
        chk("ack_noreq_proto", 32'(err_proto), 32'b11);
        chk("ack_noreq_count", 32'(err_count), 32'd2);
        clear_errors();

        // Command traffic during LP, then clear colliding with a 4th event
        lp_req[0] = 1'b1;            cycles(1);
        lp_ack[0] = 1'b1;            cycles(1);
        cmd_active[0] = 1'b1;        cycles(3);
        chk("cmd_flag",  32'(err_cmd),   32'b01);
        chk("cmd_count", 32'(err_count), 32'd3);
        err_clr = 1'b1;              cycles(1);
        err_clr = 1'b0; cmd_active[0] = 1'b0;
        chk("clr_prio_count", 32'(err_count),     32'd0);
        chk("clr_prio_cmd",   32'(err_cmd),       32'b00);
        chk("clr_keep_state", 32'(lp_state[1:0]), 32'd2);
        lp_req[0] = 1'b0;            cycles(1);
        lp_ack[0] = 1'b0;            cycles(1);

        // Five events: narrow counter saturates at 3
        lp_ack = 2'b11;              cycles(2);
        lp_ack = 2'b01;              cycles(1);
        lp_ack = 2'b00;
        chk("sat_count16", 32'(err_count),   32'd5);
        chk("sat_count2",  32'(err_count_b), 32'd3);
        clear_errors();

        // Reset in the middle of a request abandons it silently
        lp_req[0] = 1'b1;            cycles(1);
        cmd_active[0] = 1'b1;        cycles(2);
        chk("prerst_count", 32'(err_count), 32'd2);
        cmd_active[0] = 1'b0; cycles(1);
        reset = 1'b0; lp_req[0] = 1'b0; cycles(1);
        chk("midrst_state", 32'(lp_state),  32'h0);
        chk("midrst_count", 32'(err_count), 32'd0);
        reset = 1'b1;                cycles(2);
        chk("postrst_flags", 32'({err_proto, err_timeout, err_cmd, err_wakeup}), 32'h0);

        // Exit timeout and req re-assertion during EXIT on channel 1
        lp_req[1] = 1'b1;            cycles(1);
        lp_ack[1] = 1'b1;            cycles(1);
        lp_req[1] = 1'b0;            cycles(1);
        chk("exit_state", 32'(lp_state[3:2]), 32'd3);
        cycles(16);
        chk("exit_tmo_early", 32'(err_timeout), 32'b00);
        cycles(1);
        chk("exit_tmo_set",   32'(err_timeout), 32'b10);
        lp_req[1] = 1'b1;            cycles(1);
        chk("exit_reassert_proto", 32'(err_proto),     32'b10);
        chk("exit_reassert_state", 32'(lp_state[3:2]), 32'd3);
        chk("exit_count",          32'(err_count),     32'd2);
        lp_req[1] = 1'b0; lp_ack[1] = 1'b0; cycles(1);
        clear_errors();

        // Early withdrawal of a request, then traffic while idle (legal)
        lp_req[0] = 1'b1;            cycles(1);
        lp_req[0] = 1'b0;            cycles(1);
        chk("early_drop_proto", 32'(err_proto), 32'b01);
        cmd_active = 2'b11;          cycles(2);
        cmd_active = 2'b00;
        chk("idle_cmd_flag",  32'(err_cmd),   32'b00);
        chk("idle_cmd_count", 32'(err_count), 32'd1);
        clear_errors();

        // Wakeup code change while in LP
        lp_wakeup[5:0] = 6'd3;       cycles(1);
        lp_req[0] = 1'b1;            cycles(1);
        lp_ack[0] = 1'b1;            cycles(1);
        lp_wakeup[5:0] = 6'd4;       cycles(1);
`ifdef DFI_LP_WAKEUP_CHK_EN
        chk("wakeup_flag",  32'(err_wakeup), 32'b01);
        chk("wakeup_count", 32'(err_count),  32'd1);
`else
        chk("wakeup_flag",  32'(err_wakeup), 32'b00);
        chk("wakeup_count", 32'(err_count),  32'd0);
`endif
        lp_req[0] = 1'b0;            cycles(1);
        lp_ack[0] = 1'b0;            cycles(2);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
